rx_pkt_ctrl: RTL and testbench

RX_PKT_CTRL -- requirements
Module: rx_pkt_ctrl

---
 rtl/rx_pkt_ctrl.sv | 116 +++++++++++
 tb/tb_rx_pkt_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rx_pkt_ctrl.sv
// rx_pkt_ctrl: receive-side packet sequencer from request through SYNC/EOP to result hand-off.
module rx_pkt_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int DRAIN_CYC   = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_req,
  input  logic        sync_det,
  input  logic        eop_det,
  output logic        start_rc_nrzi,
  output logic        end_rc_nrzi,
  input  logic        pkt_status,
  input  logic        rc_CRCerror,
  input  logic        rc_PIDerror,
  input  logic [7:0]  rc_hshake,
  input  logic [63:0] rc_data,
  output logic        pkt_rec,
  output logic        rx_done,
  output logic [2:0]  rx_err,
  output logic [7:0]  rx_pid,
  output logic [63:0] rx_data,
  input  logic        rx_ack,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WAIT_SYNC, RECV, DRAIN, REPORT} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d, end_q, end_d, pkt_rec_q, pkt_rec_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        pid_q, pid_d;
  logic [63:0]       data_q, data_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    pkt_rec_d = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    pid_d     = pid_q;
    data_d    = data_q;
    case (state_q)
      IDLE: if (rx_req) begin
        state_d = WAIT_SYNC;
        cnt_d   = '0;
      end
      WAIT_SYNC: if (sync_det) begin
        state_d = RECV;
        start_d = 1'b1;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = REPORT;
        done_d  = 1'b1;
        err_d   = 3'b001;
      end else cnt_d = cnt_q + 1'b1;
      RECV: if (eop_det) begin
        state_d = DRAIN;
        end_d   = 1'b1;
        cnt_d   = '0;
      end
      DRAIN: if (pkt_status) begin
        state_d   = REPORT;
        done_d    = 1'b1;
        pkt_rec_d = 1'b1;
        pid_d     = rc_hshake;
        data_d    = rc_data;
        err_d     = rc_PIDerror ? 3'b011 : rc_CRCerror ? 3'b010 : 3'b000;
      end else if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
        state_d = REPORT;
        done_d  = 1'b1;
        err_d   = 3'b100;
      end else cnt_d = cnt_q + 1'b1;
      REPORT: if (rx_ack) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      pkt_rec_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 3'b000;
      pid_q     <= 8'h00;
      data_q    <= 64'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      end_q     <= end_d;
      pkt_rec_q <= pkt_rec_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      pid_q     <= pid_d;
      data_q    <= data_d;
    end
  end
  assign start_rc_nrzi = start_q;
  assign end_rc_nrzi   = end_q;
  assign pkt_rec       = pkt_rec_q;
  assign rx_done       = done_q;
  assign busy          = busy_q;
  assign rx_err        = err_q;
  assign rx_pid        = pid_q;
  assign rx_data       = data_q;
endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb_rx_pkt_ctrl: directed vectors with hand-computed expectations for rx_pkt_ctrl.
module tb_rx_pkt_ctrl;
  logic        clk = 0, rst_n = 0, rx_req = 0, sync_det = 0, eop_det = 0;
  logic        pkt_status = 0, rc_CRCerror = 0, rc_PIDerror = 0, rx_ack = 0;
  logic [7:0]  rc_hshake = 0;
  logic [63:0] rc_data = 0;
  logic        start_rc_nrzi, end_rc_nrzi, pkt_rec, rx_done, busy;
  logic [2:0]  rx_err;
  logic [7:0]  rx_pid;
  logic [63:0] rx_data;
  int vec = 0, miss = 0, ns = 0, ne = 0, np = 0, n = 0;

  rx_pkt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_req(rx_req), .sync_det(sync_det), .eop_det(eop_det),
    .start_rc_nrzi(start_rc_nrzi), .end_rc_nrzi(end_rc_nrzi), .pkt_status(pkt_status),
    .rc_CRCerror(rc_CRCerror), .rc_PIDerror(rc_PIDerror), .rc_hshake(rc_hshake),
    .rc_data(rc_data), .pkt_rec(pkt_rec), .rx_done(rx_done), .rx_err(rx_err),
    .rx_pid(rx_pid), .rx_data(rx_data), .rx_ack(rx_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    ns += int'(start_rc_nrzi);
    ne += int'(end_rc_nrzi);
    np += int'(pkt_rec);
  endtask

  task automatic quick_pkt(input logic crc, input logic pid, input logic [7:0] hs, input logic [63:0] d);
    rx_req = 1; tick; rx_req = 0;
    sync_det = 1; tick; sync_det = 0;
    eop_det = 1; tick; eop_det = 0;
    pkt_status = 1; rc_CRCerror = crc; rc_PIDerror = pid; rc_hshake = hs; rc_data = d;
    tick;
    pkt_status = 0; rc_CRCerror = 0; rc_PIDerror = 0;
  endtask

  task automatic ack;
    rx_ack = 1; tick; rx_ack = 0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_pid", rx_pid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_strobes", {start_rc_nrzi, end_rc_nrzi, pkt_rec}, 0);
    tick;
    rst_n = 1;
    // good packet
    rx_req = 1; tick; rx_req = 0;
    chk("req_first_edge", busy, 1);
    tick; tick;
    sync_det = 1; tick; sync_det = 0;
    chk("start_pulse", start_rc_nrzi, 1);
    tick;
    chk("start_one_cycle", start_rc_nrzi, 0);
    sync_det = 1; tick; sync_det = 0;
    chk("sync_ignored_recv", start_rc_nrzi, 0);
    repeat (86) tick;
    eop_det = 1; tick; eop_det = 0;
    chk("end_pulse", end_rc_nrzi, 1);
    repeat (5) tick;
    chk("drain_no_done", rx_done, 0);
    pkt_status = 1; rc_hshake = 8'hC3; rc_data = 64'hF77DB57B7D5D7F53;
    tick;
    pkt_status = 0;
    chk("pkt_rec_pulse", pkt_rec, 1);
    chk("good_done", rx_done, 1);
    chk("good_err", rx_err, 3'b000);
    chk("good_pid", rx_pid, 8'hC3);
    chk("good_data", rx_data, 64'hF77DB57B7D5D7F53);
    tick;
    chk("pkt_rec_one_cycle", pkt_rec, 0);
    chk("done_held", rx_done, 1);
    chk("pulse_counts", {32'(ns), 16'(ne), 16'(np)}, {32'd1, 16'd1, 16'd1});
    ack;
    chk("ack_done_clr", rx_done, 0);
    chk("ack_idle", busy, 0);
    // sync timeout
    ns = 0;
    rx_req = 1; tick; rx_req = 0;
    n = 0;
    while (!rx_done && n < 400) begin tick; n++; end
    chk("sync_to_cycles", 64'(n), 255);
    chk("sync_to_err", rx_err, 3'b001);
    chk("sync_to_no_start", 64'(ns), 0);
    chk("sync_to_pid_kept", rx_pid, 8'hC3);
    chk("sync_to_data_kept", rx_data, 64'hF77DB57B7D5D7F53);
    rx_req = 1; tick; rx_req = 0;
    chk("req_ignored_report", rx_done, 1);
    // ack held 3 cycles, then a fresh request must start exactly one sequence
    rx_ack = 1; tick;
    chk("ack3_c1_done", rx_done, 0);
    chk("ack3_c1_busy", busy, 0);
    tick;
    chk("ack3_c2_busy", busy, 0);
    tick; rx_ack = 0;
    chk("ack3_c3_busy", busy, 0);
    // error priority
    quick_pkt(1, 1, 8'h5A, 64'h0123456789ABCDEF);
    chk("both_err", rx_err, 3'b011);
    chk("both_pid", rx_pid, 8'h5A);
    ack;
    quick_pkt(1, 0, 8'hD2, 64'hDEADBEEFCAFEF00D);
    chk("crc_err", rx_err, 3'b010);
    chk("crc_data", rx_data, 64'hDEADBEEFCAFEF00D);
    ack;
    // drain timeout
    np = 0;
    rx_req = 1; tick; rx_req = 0;
    sync_det = 1; tick; sync_det = 0;
    eop_det = 1; tick; eop_det = 0;
    n = 0;
    while (!rx_done && n < 200) begin tick; n++; end
    chk("drain_to_cycles", 64'(n), 64);
    chk("drain_to_err", rx_err, 3'b100);
    chk("drain_to_no_pkt_rec", 64'(np), 0);
    chk("drain_to_pid_kept", rx_pid, 8'hD2);
    ack;
    // sync (with eop) on the timeout cycle
    ne = 0;
    rx_req = 1; tick; rx_req = 0;
    repeat (254) tick;
    sync_det = 1; eop_det = 1; tick; sync_det = 0; eop_det = 0;
    chk("edge_sync_start", start_rc_nrzi, 1);
    chk("edge_sync_no_done", rx_done, 0);
    chk("edge_sync_busy", busy, 1);
    tick;
    chk("edge_eop_ignored", 64'(ne), 0);
    // async reset in RECV
    rst_n = 0; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {rx_done, rx_err, rx_pid, start_rc_nrzi, end_rc_nrzi, pkt_rec}, 0);
    chk("mid_rst_data", rx_data, 0);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
